// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the data-RAM access controller: access
//               size codes, controller FSM states and alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_MERGE_WR = 3'd2,
        ST_WR       = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // Alignment rule for a given size and byte lane; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Little-endian lane handling for 32-bit words. Extracts and
//               sign/zero-extends a byte or halfword for loads, and merges a
//               byte or halfword into an existing word for stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [15:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: select the addressed lane and extend it to 32 bits.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the old word.
    always_comb begin
        o_merged_word = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0:    o_merged_word[7:0]   = i_store_data[7:0];
                    2'd1:    o_merged_word[15:8]  = i_store_data[7:0];
                    2'd2:    o_merged_word[23:16] = i_store_data[7:0];
                    default: o_merged_word[31:24] = i_store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) begin
                    o_merged_word[31:16] = i_store_data;
                end else begin
                    o_merged_word[15:0] = i_store_data;
                end
            end
            default: o_merged_word = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : CPU load/store initiator for a word-addressed data RAM without
//               byte enables. One request at a time; sub-word stores use a
//               read-modify-write sequence. Strobes decode from state flops.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_cs,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state_q,     w_state_d;
    logic                r_we_q,        w_we_d;
    logic [1:0]          r_size_q,      w_size_d;
    logic                r_uns_q,       w_uns_d;
    logic [1:0]          r_lane_q,      w_lane_d;
    logic [15:0]         r_wdata_q,     w_wdata_d;
    logic [ADDR_W-1:0]   r_mem_addr_q,  w_mem_addr_d;
    logic [DATA_W-1:0]   r_mem_wdata_q, w_mem_wdata_d;
    logic [31:0]         r_rsp_rdata_q, w_rsp_rdata_d;
    logic                r_rsp_err_q,   w_rsp_err_d;

    logic                w_addr_oor;
    logic                w_req_err;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged_word;

    // Any address bit above the RAM's byte range makes the access out of range.
    assign w_addr_oor = |(req_addr >> (ADDR_W + 2));
    assign w_req_err  = w_addr_oor | (req_size == SZ_ILLEGAL) |
                        is_misaligned(req_size, req_addr[1:0]);

    mem_lane_align u_lane_align (
        .i_word        (mem_rdata),
        .i_lane        (r_lane_q),
        .i_size        (r_size_q),
        .i_unsigned    (r_uns_q),
        .i_store_data  (r_wdata_q),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    // Next-state and datapath updates; every register holds unless changed.
    always_comb begin
        w_state_d     = r_state_q;
        w_we_d        = r_we_q;
        w_size_d      = r_size_q;
        w_uns_d       = r_uns_q;
        w_lane_d      = r_lane_q;
        w_wdata_d     = r_wdata_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;

        case (r_state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    w_we_d        = req_we;
                    w_size_d      = req_size;
                    w_uns_d       = req_unsigned;
                    w_lane_d      = req_addr[1:0];
                    w_wdata_d     = req_wdata[15:0];
                    w_rsp_err_d   = w_req_err;
                    w_rsp_rdata_d = 32'd0;
                    if (w_req_err) begin
                        // RAM address/data are left untouched for rejected requests.
                        w_state_d = ST_RESP;
                    end else begin
                        w_mem_addr_d = req_addr[ADDR_W+1:2];
                        if (!req_we) begin
                            w_state_d = ST_RD;
                        end else if (req_size == SZ_WORD) begin
                            w_mem_wdata_d = req_wdata;
                            w_state_d     = ST_WR;
                        end else begin
                            w_state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                if (r_we_q) begin
                    w_mem_wdata_d = w_merged_word;
                    w_state_d     = ST_MERGE_WR;
                end else begin
                    w_rsp_rdata_d = w_load_data;
                    w_state_d     = ST_RESP;
                end
            end
            ST_MERGE_WR, ST_WR: begin
                w_state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_we_q        <= 1'b0;
            r_size_q      <= SZ_BYTE;
            r_uns_q       <= 1'b0;
            r_lane_q      <= 2'd0;
            r_wdata_q     <= 16'd0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_rsp_rdata_q <= 32'd0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_we_q        <= w_we_d;
            r_size_q      <= w_size_d;
            r_uns_q       <= w_uns_d;
            r_lane_q      <= w_lane_d;
            r_wdata_q     <= w_wdata_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    // Handshake and RAM strobes decoded purely from the registered state.
    always_comb begin
        req_ready    = (r_state_q == ST_IDLE);
        rsp_valid    = (r_state_q == ST_RESP);
        mem_read_en  = (r_state_q == ST_RD);
        mem_write_en = (r_state_q == ST_WR) || (r_state_q == ST_MERGE_WR);
        mem_cs       = mem_read_en || mem_write_en;
    end

    assign mem_addr  = r_mem_addr_q;
    assign mem_wdata = r_mem_wdata_q;
    assign rsp_rdata = r_rsp_rdata_q;
    assign rsp_err   = r_rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Scoreboard bench for mem_access_ctrl with a byte-array
//               reference memory, a RAM model and random backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_cs, mem_read_en, mem_write_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram   [0:1023];
    logic [7:0]  ref_b [0:4095];

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          base_rd = 0, base_wr = 0, n_rd = 0, n_wr = 0;
    int          hold_cnt = 0;
    logic [9:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_cs       (mem_cs),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // RAM model: asynchronous read while selected, write on the clock edge.
    assign mem_rdata = (mem_cs && mem_read_en) ? ram[mem_addr] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_cs && mem_write_en) ram[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pfail(input string name, input logic [31:0] act, input logic [31:0] exp);
        miscompares++;
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference behaviour on a byte-addressed memory of 4096 bytes.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          n;
        logic [31:0] v, t;
        n       = (sz == 2'd3) ? 1 : (1 << sz);
        e.rdata = 32'd0;
        e.err   = (addr >= 32'd4096) || (sz == 2'd3) || ((addr % n) != 0);
        if (e.err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (we) begin
            for (int i = 0; i < n; i++) begin
                t = wd >> (8 * i);
                ref_b[addr + i] = t[7:0];
            end
            e.lat = (n == 4) ? 2 : 3;
            e.nrd = (n == 4) ? 0 : 1;
            e.nwr = 1;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | ({24'd0, ref_b[addr + i]} << (8 * i));
            if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
            e.lat = 2; e.nrd = 1; e.nwr = 0;
        end
        return e;
    endfunction

    task automatic present(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, output bit ok);
        int t;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = req_ready;
        if (!ok) pfail("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        else begin
            @(posedge clk);
            #1;
            accept_cyc = cyc; base_rd = n_rd; base_wr = n_wr;
        end
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit ok;
        sb.push_back(model(we, sz, uns, addr, wd));
        present(we, sz, uns, addr, wd, ok);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) pfail("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"},    {31'd0, req_ready},    32'd1);
        chk({tag, "_rsp_valid"},    {31'd0, rsp_valid},    32'd0);
        chk({tag, "_rsp_err"},      {31'd0, rsp_err},      32'd0);
        chk({tag, "_rsp_rdata"},    rsp_rdata,             32'd0);
        chk({tag, "_mem_cs"},       {31'd0, mem_cs},       32'd0);
        chk({tag, "_mem_read_en"},  {31'd0, mem_read_en},  32'd0);
        chk({tag, "_mem_write_en"}, {31'd0, mem_write_en}, 32'd0);
        chk({tag, "_mem_addr"},     {22'd0, mem_addr},     32'd0);
        chk({tag, "_mem_wdata"},    mem_wdata,             32'd0);
    endtask

    // Response backpressure: random, or forced low while hold_cnt runs.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                rsp_ready = 1'b0;
                hold_cnt--;
            end else begin
                rsp_ready = ($urandom % 4) != 0;
            end
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pop on each response.
    initial begin
        bit          seen, prev_hs, prev_hold, prev_err;
        logic [31:0] prev_rdata;
        int          lat;
        exp_t        e;
        seen = 0; prev_hs = 0; prev_hold = 0; prev_err = 0; prev_rdata = '0; lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0; prev_hs = 0; prev_hold = 0;
            end else begin
                if (mem_cs && mem_read_en) n_rd++;
                if (mem_cs && mem_write_en) begin
                    n_wr++;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                end
                if (mem_read_en && mem_write_en) pfail("rd_wr_overlap", 32'd1, 32'd0);
                if (!mem_cs && (mem_read_en || mem_write_en)) pfail("enable_without_cs", 32'd1, 32'd0);
                if (rsp_valid && mem_cs) pfail("strobe_in_resp", 32'd1, 32'd0);
                if (rsp_valid && req_ready) pfail("req_ready_in_resp", 32'd1, 32'd0);
                if (prev_hs && !req_ready) pfail("accept_resume", 32'd0, 32'd1);
                if (prev_hold) begin
                    if (!rsp_valid) pfail("rsp_valid_dropped", 32'd0, 32'd1);
                    else begin
                        if (rsp_rdata !== prev_rdata) pfail("rsp_rdata_unstable", rsp_rdata, prev_rdata);
                        if (rsp_err !== prev_err) pfail("rsp_err_unstable", {31'd0, rsp_err}, {31'd0, prev_err});
                    end
                end
                if (rsp_valid && !seen) begin
                    seen = 1;
                    lat  = cyc - accept_cyc + 1;
                end
                if (rsp_valid && rsp_ready) begin
                    seen = 0;
                    if (sb.size() == 0) pfail("unexpected_response", rsp_rdata, 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_err",   {31'd0, rsp_err}, {31'd0, e.err});
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("latency",   lat, e.lat);
                        chk("ram_reads", n_rd - base_rd, e.nrd);
                        chk("ram_writes", n_wr - base_wr, e.nwr);
                    end
                end
                prev_hs    = rsp_valid && rsp_ready;
                prev_hold  = rsp_valid && !rsp_ready;
                prev_rdata = rsp_rdata;
                prev_err   = rsp_err;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   bad;
        logic [31:0] w;
        logic [1:0]  sz;

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            ram[i] = w;
            ref_b[4*i]   = w[7:0];
            ref_b[4*i+1] = w[15:8];
            ref_b[4*i+2] = w[23:16];
            ref_b[4*i+3] = w[31:24];
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Word store then word load.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        drain();
        chk("t1_wr_addr", {22'd0, last_wr_addr}, 32'd4);
        chk("t1_wr_data", last_wr_data, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Byte store read-modify-write, then signed and unsigned byte loads.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFF_FFAA);
        drain();
        chk("t2_wr_addr", {22'd0, last_wr_addr}, 32'd4);
        chk("t2_wr_data", last_wr_data, 32'hAA223344);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

        // Halfword loads with sign and zero extension.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7FFF);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);

        // Error requests.
        issue(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h05, 32'h1234);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h24, 32'h0);
        drain();

        // Long response backpressure on a load.
        hold_cnt = 9;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        drain();

        // Reset during the read phase of a byte store aborts the write.
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        drain();
        present(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0055, ok);
        @(negedge clk);
        chk("t6_in_read", {31'd0, mem_read_en}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("abort");
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        drain();

        // Random traffic over a small window plus occasional bad requests.
        for (int k = 0; k < 300; k++) begin
            w  = 32'h100 + $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) w = w | (32'd1 << $urandom_range(12, 31));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), w, $urandom);
        end
        drain();

        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (ram[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]}) bad++;
        end
        chk("ram_final_bad_words", bad, 32'd0);
        chk("scoreboard_left", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
